// File: rtl/slot_alloc_pkg.sv
// rtl/slot_alloc_pkg.sv - shared sizing and slot types for the slot allocator
// Ports: none (package).
package slot_alloc_pkg;

    localparam int W_DEF = 32;
    localparam int ID_W  = $clog2(W_DEF);

    typedef logic [ID_W-1:0] slot_id_t;
    typedef logic [ID_W:0]   slot_cnt_t;

endpackage

// File: rtl/slot_alloc_if.sv
// rtl/slot_alloc_if.sv - alloc/free/status bundle between a client and the slot allocator
// Ports: alloc_vld_i/alloc_rdy_o/alloc_id_o (grant), free_vld_i/free_id_i (release),
//        flush_i, busy_o, cnt_o, empty_o, full_o, err_o.
interface slot_alloc_if
    import slot_alloc_pkg::*;
#(
    parameter int W = W_DEF
);
    logic                 alloc_vld_i;
    logic                 alloc_rdy_o;
    logic [$clog2(W)-1:0] alloc_id_o;
    logic                 free_vld_i;
    logic [$clog2(W)-1:0] free_id_i;
    logic                 flush_i;
    logic [W-1:0]         busy_o;
    logic [$clog2(W):0]   cnt_o;
    logic                 empty_o;
    logic                 full_o;
    logic                 err_o;

    modport master (
        output alloc_vld_i, free_vld_i, free_id_i, flush_i,
        input  alloc_rdy_o, alloc_id_o, busy_o, cnt_o, empty_o, full_o, err_o
    );

    modport slave (
        input  alloc_vld_i, free_vld_i, free_id_i, flush_i,
        output alloc_rdy_o, alloc_id_o, busy_o, cnt_o, empty_o, full_o, err_o
    );
endinterface

// File: rtl/slot_alloc_r.sv
// rtl/slot_alloc_r.sv - next-free search: first clear bit of x_i below pos_i, descending with wrap
// Ports: x_i (busy bitmap), pos_i (search pointer), any_o (some bit clear), y_enc_o (found index).
module slot_alloc_r #(
    parameter int W = 32
) (
    input  logic [W-1:0]         x_i,
    input  logic [$clog2(W)-1:0] pos_i,
    output logic                 any_o,
    output logic [$clog2(W)-1:0] y_enc_o
);
    localparam int IW = $clog2(W);

    logic [W-1:0] free_v;
    logic [W-1:0] lo_mask;
    logic [W-1:0] below;
    logic [W-1:0] sel;

    // Descending from pos_i-1 means: highest free slot strictly below pos_i,
    // otherwise (wrap) the highest free slot overall.
    always_comb begin
        free_v  = ~x_i;
        lo_mask = (W'(1) << pos_i) - W'(1);
        below   = free_v & lo_mask;
        any_o   = |free_v;
        sel     = (|below) ? below : free_v;
        y_enc_o = '0;
        for (int i = 0; i < W; i++) begin
            if (sel[i]) begin
                y_enc_o = IW'(i);
            end
        end
    end
endmodule

// File: rtl/slot_alloc.sv
// rtl/slot_alloc.sv - descending round-robin slot allocator over a registered busy bitmap
// Ports: clk, arst_n (async active-low), bus (slot_alloc_if.slave: alloc/free/flush and status).
module slot_alloc
    import slot_alloc_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         arst_n,
    slot_alloc_if.slave  bus
);
    localparam int IW = $clog2(W);

    logic [W-1:0]  busy_r;
    logic [IW-1:0] pos_r;
    logic [IW:0]   cnt_r;
    logic          err_r;

    logic          any;
    logic [IW-1:0] srch_id;
    logic          grant;
    logic          free_ok;
    logic          free_bad;
    logic [W-1:0]  set_mask;
    logic [W-1:0]  clr_mask;
    logic [IW:0]   cnt_nxt;

    function automatic logic [W-1:0] onehot(input logic [IW-1:0] id);
        logic [W-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    slot_alloc_r #(.W(W)) u_r (
        .x_i     (busy_r),
        .pos_i   (pos_r),
        .any_o   (any),
        .y_enc_o (srch_id)
    );

    // Grant and free both look at pre-edge busy_r, so a granted slot was free
    // and a freed slot was busy: the two masks never touch the same bit.
    always_comb begin
        grant    = bus.alloc_vld_i & any;
        free_ok  = bus.free_vld_i &  busy_r[bus.free_id_i];
        free_bad = bus.free_vld_i & ~busy_r[bus.free_id_i];
        set_mask = grant   ? onehot(srch_id)        : '0;
        clr_mask = free_ok ? onehot(bus.free_id_i)  : '0;
        case ({grant, free_ok})
            2'b10:   cnt_nxt = cnt_r + (IW+1)'(1);
            2'b01:   cnt_nxt = cnt_r - (IW+1)'(1);
            default: cnt_nxt = cnt_r;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_r <= '0;
            pos_r  <= '0;
            cnt_r  <= '0;
            err_r  <= 1'b0;
        end else if (bus.flush_i) begin
            busy_r <= '0;
            pos_r  <= '0;
            cnt_r  <= '0;
        end else begin
            busy_r <= (busy_r & ~clr_mask) | set_mask;
            cnt_r  <= cnt_nxt;
            if (grant) begin
                pos_r <= srch_id;
            end
            if (free_bad) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.alloc_rdy_o = any;
    assign bus.alloc_id_o  = srch_id;
    assign bus.busy_o      = busy_r;
    assign bus.cnt_o       = cnt_r;
    assign bus.empty_o     = (cnt_r == '0);
    assign bus.full_o      = (cnt_r == (IW+1)'(W));
    assign bus.err_o       = err_r;
endmodule

// File: tb/tb_slot_alloc.sv
// tb/tb_slot_alloc.sv - self-checking bench for slot_alloc at W=8
module tb_slot_alloc;
    localparam int W = 8;

    logic clk;
    logic arst_n;

    slot_alloc_if #(.W(W)) bus ();

    slot_alloc #(.W(W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: which slots are held, where the last grant went,
    // how many are held, and whether a bad free was ever seen.
    bit [W-1:0] m_busy;
    int         m_pos;
    int         m_cnt;
    bit         m_err;

    typedef struct {
        bit alloc; bit fv; int fid; bit fl;
        bit rdy;   int id;  int busy; int cnt; bit full; bit err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Walk the slots below the last grant, wrapping, and return the first free one.
    function automatic int m_search();
        for (int k = 1; k <= W; k++) begin
            int idx;
            idx = (m_pos - k + W) % W;
            if (!m_busy[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = '0;
        m_pos  = 0;
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    // Caller is at posedge+1; inputs are applied for one edge, then dropped.
    task automatic step(input bit a, input bit fv, input int fid, input bit fl);
        int s;
        bus.alloc_vld_i = a;
        bus.free_vld_i  = fv;
        bus.free_id_i   = 3'(fid);
        bus.flush_i     = fl;
        s = m_search();
        @(posedge clk);
        if (fl) begin
            m_busy = '0;
            m_pos  = 0;
            m_cnt  = 0;
        end else begin
            if (fv) begin
                if (m_busy[fid]) begin
                    m_busy[fid] = 1'b0;
                    m_cnt--;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (a && s >= 0) begin
                m_busy[s] = 1'b1;
                m_pos     = s;
                m_cnt++;
            end
        end
        #1;
        bus.alloc_vld_i = 1'b0;
        bus.free_vld_i  = 1'b0;
        bus.free_id_i   = '0;
        bus.flush_i     = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        int s;
        s = m_search();
        chk({tag, "_rdy"}, bus.alloc_rdy_o, (s >= 0));
        if (s >= 0) chk({tag, "_id"}, bus.alloc_id_o, s);
        chk({tag, "_busy"},  bus.busy_o,  m_busy);
        chk({tag, "_cnt"},   bus.cnt_o,   m_cnt);
        chk({tag, "_empty"}, bus.empty_o, (m_cnt == 0));
        chk({tag, "_full"},  bus.full_o,  (m_cnt == W));
        chk({tag, "_err"},   bus.err_o,   m_err);
    endtask

    task automatic do_reset();
        arst_n          = 1'b0;
        bus.alloc_vld_i = 1'b0;
        bus.free_vld_i  = 1'b0;
        bus.free_id_i   = '0;
        bus.flush_i     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    initial begin
        // alloc fv fid fl | rdy id busy cnt full err
        tbl.push_back('{1,0,0,0, 1,7,'h80,1,0,0});
        tbl.push_back('{1,0,0,0, 1,6,'hC0,2,0,0});
        tbl.push_back('{1,0,0,0, 1,5,'hE0,3,0,0});
        tbl.push_back('{1,0,0,0, 1,4,'hF0,4,0,0});
        tbl.push_back('{1,0,0,0, 1,3,'hF8,5,0,0});
        tbl.push_back('{1,0,0,0, 1,2,'hFC,6,0,0});
        tbl.push_back('{1,0,0,0, 1,1,'hFE,7,0,0});
        tbl.push_back('{1,0,0,0, 1,0,'hFF,8,1,0});
        tbl.push_back('{1,0,0,0, 0,-1,'hFF,8,1,0});
        tbl.push_back('{0,1,5,0, 0,-1,'hDF,7,0,0});
        tbl.push_back('{1,0,0,0, 1,5,'hFF,8,1,0});
        tbl.push_back('{1,1,2,0, 0,-1,'hFB,7,0,0});
        tbl.push_back('{1,0,0,0, 1,2,'hFF,8,1,0});
        tbl.push_back('{1,0,0,1, 0,-1,'h00,0,0,0});
        tbl.push_back('{1,0,0,0, 1,7,'h80,1,0,0});
        tbl.push_back('{1,0,0,1, 1,6,'h00,0,0,0});
        tbl.push_back('{0,1,4,0, 1,7,'h00,0,0,1});
        tbl.push_back('{0,0,0,1, 1,7,'h00,0,0,1});
        tbl.push_back('{1,0,0,0, 1,7,'h80,1,0,1});

        do_reset();
        chk("rst_rdy",   bus.alloc_rdy_o, 1);
        chk("rst_id",    bus.alloc_id_o,  W - 1);
        chk("rst_empty", bus.empty_o,     1);
        chk("rst_full",  bus.full_o,      0);
        chk("rst_busy",  bus.busy_o,      0);
        chk("rst_cnt",   bus.cnt_o,       0);
        chk("rst_err",   bus.err_o,       0);

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("tbl%0d", i);
            chk({tag, "_rdy"}, bus.alloc_rdy_o, tbl[i].rdy);
            if (tbl[i].id >= 0) chk({tag, "_id"}, bus.alloc_id_o, tbl[i].id);
            step(tbl[i].alloc, tbl[i].fv, tbl[i].fid, tbl[i].fl);
            chk({tag, "_busy"},  bus.busy_o,  tbl[i].busy);
            chk({tag, "_cnt"},   bus.cnt_o,   tbl[i].cnt);
            chk({tag, "_full"},  bus.full_o,  tbl[i].full);
            chk({tag, "_empty"}, bus.empty_o, (tbl[i].cnt == 0));
            chk({tag, "_err"},   bus.err_o,   tbl[i].err);
        end

        // Asynchronous reset between edges, with state and err set.
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy_o,      0);
        chk("arst_cnt",  bus.cnt_o,       0);
        chk("arst_err",  bus.err_o,       0);
        chk("arst_id",   bus.alloc_id_o,  W - 1);
        chk("arst_rdy",  bus.alloc_rdy_o, 1);
        do_reset();

        // Wrap case: busy=0010_0111 with pointer at 3.
        repeat (W) step(1, 0, 0, 0);
        step(0, 1, 3, 0);
        chk("wrap_pre_id", bus.alloc_id_o, 3);
        step(1, 0, 0, 0);
        step(0, 1, 7, 0);
        step(0, 1, 6, 0);
        step(0, 1, 4, 0);
        step(0, 1, 3, 0);
        chk("wrap_busy", bus.busy_o,     'h27);
        chk("wrap_id0",  bus.alloc_id_o, 7);
        step(1, 0, 0, 0);
        chk("wrap_id1",  bus.alloc_id_o, 6);
        step(1, 0, 0, 0);
        chk("wrap_busy2", bus.busy_o, 'hE7);
        chk_model("wrap_end");

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bit a, fv, fl;
            int fid;
            a   = ($urandom % 3) != 0;
            fv  = ($urandom % 2) == 1;
            fid = $urandom % W;
            fl  = ($urandom % 60) == 0;
            step(a, fv, fid, fl);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
